qick_fifo_axis_reader: RTL



---
 rtl/qick_fifo_axis_reader.sv | 111 +++++++++++
 1 files changed

// File: rtl/qick_fifo_axis_reader.sv
// Read-side drain engine: pops a fixed-latency FIFO into a 4-entry buffer and presents
// the words as an AXI-Stream master with tlast framing and a running beat counter.
module qick_fifo_axis_reader #(
  parameter int DW     = 32,
  parameter int RD_LAT = 1,
  parameter int LEN_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic [LEN_W-1:0] pkt_len_i,
  input  logic             fifo_empty_i,
  output logic             fifo_pop_o,
  input  logic [DW-1:0]    fifo_dt_i,
  output logic             m_axis_tvalid_o,
  input  logic             m_axis_tready_i,
  output logic [DW-1:0]    m_axis_tdata_o,
  output logic             m_axis_tlast_o,
  output logic [31:0]      word_cnt_o
);
  localparam int DEPTH = 4;

  logic [DW-1:0]     buf_q [DEPTH];
  logic [DW-1:0]     buf_d [DEPTH];
  logic [1:0]        rd_ptr_q, rd_ptr_d;
  logic [1:0]        wr_ptr_q, wr_ptr_d;
  logic [2:0]        occ_q, occ_d;
  logic [RD_LAT-1:0] infl_q, infl_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [31:0]       word_cnt_q, word_cnt_d;

  logic [2:0] infl_cnt;
  logic       tvalid, tlast, hs, wr_en, pop;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned (no latches).
    infl_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) infl_cnt = infl_cnt + 3'(infl_q[i]);

    tvalid = (occ_q != '0);
    hs     = tvalid && m_axis_tready_i;
    wr_en  = infl_q[RD_LAT-1];
    tlast  = tvalid && (len_q != '0) && (beat_cnt_q == len_q - LEN_W'(1));
    // Credits come from registered state only; a same-cycle handshake frees nothing.
    pop    = !fifo_empty_i && ((occ_q + infl_cnt) < 3'(DEPTH)) && !flush_i && rst_ni;

    buf_d = buf_q;
    if (wr_en) buf_d[wr_ptr_q] = fifo_dt_i;

    infl_d   = RD_LAT'({infl_q, pop});
    wr_ptr_d = wr_ptr_q + 2'(wr_en);
    rd_ptr_d = rd_ptr_q + 2'(hs);

    case ({wr_en, hs})
      2'b10:   occ_d = occ_q + 3'd1;
      2'b01:   occ_d = occ_q - 3'd1;
      default: occ_d = occ_q;
    endcase

    beat_cnt_d = beat_cnt_q;
    if (hs) beat_cnt_d = tlast ? '0 : beat_cnt_q + LEN_W'(1);

    // At a packet boundary the length follows pkt_len_i, frozen while a beat is stalled.
    len_d = len_q;
    if ((beat_cnt_d == '0) && !(tvalid && !m_axis_tready_i)) len_d = pkt_len_i;

    word_cnt_d = word_cnt_q + 32'(hs);

    if (flush_i) begin
      occ_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      infl_d     = '0;
      beat_cnt_d = '0;
      word_cnt_d = '0;
      len_d      = pkt_len_i;
    end
  end

  // NOTE: the data array has no reset; occ_q alone decides which entries are live.
  always_ff @(posedge clk_i) buf_q <= buf_d;

  // NOTE: state registers use non-blocking assignments; the combinational block above uses blocking.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      occ_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      infl_q     <= '0;
      beat_cnt_q <= '0;
      word_cnt_q <= '0;
      len_q      <= pkt_len_i;
    end else begin
      occ_q      <= occ_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      infl_q     <= infl_d;
      beat_cnt_q <= beat_cnt_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
    end
  end

  assign fifo_pop_o      = pop;
  assign m_axis_tvalid_o = tvalid;
  assign m_axis_tdata_o  = tvalid ? buf_q[rd_ptr_q] : '0;
  assign m_axis_tlast_o  = tlast;
  assign word_cnt_o      = word_cnt_q;

endmodule
